// File: rtl/sfr_pkg.sv
// sfr_pkg: shared state encoding, address-map constants and APB address helper for the SFR arbiter
package sfr_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } sfr_state_e;
  localparam int SFR_ADDR_LSB = 2;
  localparam int SFR_IDX_W = 6;
  localparam int SFR_NUM_REGS_DEFAULT = 8;
  function automatic logic [31:0] sfr_paddr(input logic [SFR_IDX_W-1:0] idx);
    return {{(32-SFR_IDX_W-SFR_ADDR_LSB){1'b0}}, idx, {SFR_ADDR_LSB{1'b0}}};
  endfunction
endpackage

// File: rtl/sfr_rr_arb2.sv
// sfr_rr_arb2: combinational two-way pick, round-robin or m0-priority on a tie
// Ports: req[1:0] pending requests, last_grant previous winner, fixed_prio 1 = m0 wins ties,
//        gnt_valid some request pending, gnt_id winning requester
module sfr_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       fixed_prio,
  output logic       gnt_valid,
  output logic       gnt_id
);
  always_comb begin
    gnt_valid = |req;
    gnt_id = &req ? (!fixed_prio && !last_grant) : req[1];
  end
endmodule

// File: rtl/sfr_apb_arb.sv
// sfr_apb_arb: two-requester APB master serialising req/done transactions onto the SFR bank
// Ports: sys_clk, rst_b (async, active-low);
//        m0_*/m1_* requester side: req/write/addr/wdata in, done/err/rdata out;
//        apb_sfr_* APB master outputs, sfr_apb_prdata read data in;
//        arb_owner current grant, arb_busy transaction in flight
module sfr_apb_arb import sfr_pkg::*; #(
  parameter int NUM_REGS   = SFR_NUM_REGS_DEFAULT,
  parameter int FIXED_PRIO = 0
) (
  input  logic        sys_clk,
  input  logic        rst_b,
  input  logic        m0_req,
  input  logic        m0_write,
  input  logic [7:0]  m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_done,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_write,
  input  logic [7:0]  m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_done,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic        apb_sfr_psel,
  output logic        apb_sfr_penable,
  output logic        apb_sfr_pwrite,
  output logic [31:0] apb_sfr_paddr,
  output logic [31:0] apb_sfr_pwdata,
  input  logic [31:0] sfr_apb_prdata,
  output logic        arb_owner,
  output logic        arb_busy
);
  sfr_state_e state, state_nx;
  logic last_grant, gnt_valid, gnt_id, cur_id, sel_ok, sel_write, fin, fin_err, fin_rd;
  logic [SFR_IDX_W-1:0] sel_idx;
  logic [31:0] sel_wdata, fin_rdata;
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{m0_addr[SFR_ADDR_LSB-1:0], m1_addr[SFR_ADDR_LSB-1:0]};
  sfr_rr_arb2 u_arb (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant),
    .fixed_prio (FIXED_PRIO != 0),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );
  always_comb begin
    sel_idx = gnt_id ? m1_addr[7:SFR_ADDR_LSB] : m0_addr[7:SFR_ADDR_LSB];
    sel_write = gnt_id ? m1_write : m0_write;
    sel_wdata = gnt_id ? m1_wdata : m0_wdata;
    sel_ok = {1'b0, sel_idx} < (SFR_IDX_W+1)'(NUM_REGS);
    state_nx = state == IDLE   ? (gnt_valid ? (sel_ok ? SETUP : DONE) : IDLE) :
               state == SETUP  ? ACCESS :
               state == ACCESS ? DONE : IDLE;
    // Completion is decided either straight out of IDLE (range error) or at the end of ACCESS
    cur_id = state == IDLE ? gnt_id : arb_owner;
    fin = state_nx == DONE;
    fin_err = state == IDLE;
    fin_rd = state == IDLE || !apb_sfr_pwrite;
    fin_rdata = state == IDLE ? 32'd0 : sfr_apb_prdata;
  end
  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      last_grant <= 1'b1;
      arb_owner <= 1'b0;
      arb_busy <= 1'b0;
      apb_sfr_psel <= 1'b0;
      apb_sfr_penable <= 1'b0;
      apb_sfr_pwrite <= 1'b0;
      apb_sfr_paddr <= 32'd0;
      apb_sfr_pwdata <= 32'd0;
      m0_done <= 1'b0;
      m0_err <= 1'b0;
      m0_rdata <= 32'd0;
      m1_done <= 1'b0;
      m1_err <= 1'b0;
      m1_rdata <= 32'd0;
    end else begin
      state <= state_nx;
      arb_busy <= state_nx != IDLE;
      apb_sfr_psel <= state_nx == SETUP || state_nx == ACCESS;
      apb_sfr_penable <= state_nx == ACCESS;
      if (state == IDLE && gnt_valid) begin
        last_grant <= gnt_id;
        arb_owner <= gnt_id;
      end
      // The APB registers double as the transaction latch; out-of-range grants leave them alone
      if (state_nx == SETUP) begin
        apb_sfr_pwrite <= sel_write;
        apb_sfr_paddr <= sfr_paddr(sel_idx);
        apb_sfr_pwdata <= sel_wdata;
      end
      m0_done <= fin && !cur_id;
      m1_done <= fin && cur_id;
      if (fin && !cur_id) begin
        m0_err <= fin_err;
        if (fin_rd) m0_rdata <= fin_rdata;
      end
      if (fin && cur_id) begin
        m1_err <= fin_err;
        if (fin_rd) m1_rdata <= fin_rdata;
      end
    end
  end
endmodule
